// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: tracks EX/MEM destination metadata to drive
// EX operand forwarding selects, load-use stalls, branch flushes and saturating event counters.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_to_reg,
   input  logic             ex_branch_taken,
   output logic             stall_if,
   output logic             stall_id,
   output logic             bubble_ex,
   output logic             flush_id,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

   state_t     state;
   logic       armed;
   // WB is not shadowed: the register file is write-through, so a WB producer never needs a select.
   logic [4:0] shadowRd_p0, shadowRd_p1;
   logic       shadowWe_p0, shadowWe_p1;
   logic       shadowLoad_p0;
   logic       active;
   logic       loadUse;
   logic       idWe;
   logic [1:0] selA, selB;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt, input logic inc);
      if (inc && (cnt != {CNT_W{1'b1}}))
         return cnt + CNT_W'(1);
      return cnt;
   endfunction

   function automatic logic loadHit(input logic reads, input logic [4:0] rs,
                                    input logic [4:0] exRd, input logic exLoad);
      return reads && exLoad && (rs == exRd);
   endfunction

   function automatic logic [1:0] fwdSel(input logic reads, input logic [4:0] rs,
                                         input logic [4:0] exRd, input logic exWe,
                                         input logic [4:0] memRd, input logic memWe);
      if (!reads || (rs == 5'd0))
         return 2'b00;
      if (exWe && (rs == exRd))
         return 2'b01;
      if (memWe && (rs == memRd))
         return 2'b10;
      return 2'b00;
   endfunction

   always_comb begin
      // Controls stay quiet during reset and in the first cycle after it.
      active    = armed && !reset;
      loadUse   = id_valid && (state != LDSTALL) &&
                  (loadHit(id_use_rs1, id_rs1, shadowRd_p0, shadowLoad_p0) ||
                   loadHit(id_use_rs2, id_rs2, shadowRd_p0, shadowLoad_p0));
      flush_id  = active && ex_branch_taken;
      stall_if  = active && loadUse && !ex_branch_taken;
      stall_id  = stall_if;
      bubble_ex = flush_id || stall_if;
      idWe      = id_valid && id_reg_write && (id_rd != 5'd0);
      selA      = fwdSel(id_use_rs1, id_rs1, shadowRd_p0, shadowWe_p0, shadowRd_p1, shadowWe_p1);
      selB      = fwdSel(id_use_rs2, id_rs2, shadowRd_p0, shadowWe_p0, shadowRd_p1, shadowWe_p1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         armed         <= 1'b0;
         shadowRd_p0   <= 5'd0;
         shadowWe_p0   <= 1'b0;
         shadowLoad_p0 <= 1'b0;
         shadowRd_p1   <= 5'd0;
         shadowWe_p1   <= 1'b0;
         fwd_a_sel     <= 2'b00;
         fwd_b_sel     <= 2'b00;
         stall_count   <= '0;
         flush_count   <= '0;
      end else begin
         armed <= 1'b1;
         case (state)
            RUN:     state <= flush_id ? FLUSH : (stall_if ? LDSTALL : RUN);
            LDSTALL: state <= flush_id ? FLUSH : RUN;
            FLUSH:   state <= flush_id ? FLUSH : RUN;
            default: state <= RUN;
         endcase

         // ID -> EX boundary
         if (bubble_ex) begin
            shadowRd_p0   <= 5'd0;
            shadowWe_p0   <= 1'b0;
            shadowLoad_p0 <= 1'b0;
            fwd_a_sel     <= 2'b00;
            fwd_b_sel     <= 2'b00;
         end else begin
            shadowRd_p0   <= idWe ? id_rd : 5'd0;
            shadowWe_p0   <= idWe;
            shadowLoad_p0 <= idWe && id_mem_to_reg;
            fwd_a_sel     <= id_valid ? selA : 2'b00;
            fwd_b_sel     <= id_valid ? selB : 2'b00;
         end

         // EX -> MEM boundary
         shadowRd_p1 <= shadowRd_p0;
         shadowWe_p1 <= shadowWe_p0;

         stall_count <= satInc(stall_count, stall_if);
         flush_count <= satInc(flush_count, flush_id);
      end
   end

endmodule
